regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Sequences the single write port of the 32x32 register file between two writeback producers: the ALU and the load/memory unit.
- Each producer uses a valid/ready handshake.
- Arbitration is round-robin.
- The winning write is registered and driven onto the register file's write_data/write_address/RegWrite one cycle later.
- The block also holds a busy scoreboard: issue marks a destination register pending, and the committed writeback clears it. Decode uses this scoreboard for hazard stalls.

Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers; equals 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request granted this cycle
- alu_addr  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load request granted this cycle
- mem_addr  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- issue_valid  input  1  instruction issued with a destination register
- issue_addr  input  ADDR_WIDTH  destination of the issued instruction
- rf_we  output  1  to register file RegWrite
- rf_waddr  output  ADDR_WIDTH  to register file write_address
- rf_wdata  output  DATA_WIDTH  to register file write_data
- busy_vec  output  NUM_REGS  bit i = register i has a pending write

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, last_grant=MEM (so the ALU wins the first contention). Ready outputs are 0 while in reset.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - Producers hold valid, addr and data stable until the transfer.
  - valid must not depend on ready.
  - ready is combinational from the valids and last_grant. The output stage never stalls.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the source that is not last_grant.
  - last_grant updates only on a transfer.
  - Neither valid: no grant; last_grant is held.
- Output stage, latency 1 cycle: on a transfer, next cycle rf_we=1, rf_waddr=granted addr, rf_wdata=granted data. With no transfer, rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Register 0:
  - A transfer with addr=0 is accepted (ready=1), but rf_we stays 0 the next cycle.
  - issue_addr=0 never sets busy[0]; busy_vec[0] is always 0.
- Scoreboard:
  - busy[issue_addr] is set on the clock edge where issue_valid=1.
  - busy[rf_waddr] is cleared on the edge where rf_we=1 (commit).
  - Set and clear of the same register on the same edge: set wins, because a newer producer is in flight.
  - Set and clear of different registers on the same edge: both take effect.
- Same destination from both sources in one cycle: the write is serialized by grant order. The register file ends with the second-granted value.
- Reset mid-operation: the pending output write is discarded (rf_we forced to 0 asynchronously) and the scoreboard is cleared. Producers re-present after reset.
- Throughput: one write per cycle. Under sustained dual requests the grants alternate strictly, so neither source is starved longer than 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants
  - source encoding SRC_ALU=0, SRC_MEM=1
  - ZERO_REG=0
- Natural sub-module: rr_arbiter2, a two-requester round-robin with last_grant state. It returns a one-hot grant and updates on an accept pulse.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with busy_vec=0x0000_0006 and a pending write -> rf_we=0, busy_vec=0 immediately, with no clock edge needed.
- Single source: alu_valid=1, addr=3, data=0xDEAD_BEEF, cycle N -> alu_ready=1 at N; rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF at N+1.
- Contention right after reset: both valid (ALU addr 4 data 0x11, MEM addr 5 data 0x22) -> ALU granted at N, MEM at N+1; rf writes 4/0x11 at N+1 and 5/0x22 at N+2.
- Sustained contention over 6 cycles -> grants alternate ALU, MEM, ALU, MEM, ALU, MEM; each ready is low on alternate cycles.
- Scoreboard: issue addr 7 -> busy_vec[7]=1. Then on the rf_we commit to addr 7 together with issue_valid addr 7 in the same cycle -> busy_vec[7] stays 1.
- Register zero: MEM transfer addr=0 data=0xFFFF_FFFF -> mem_ready=1, rf_we=0 next cycle. Issue addr 0 -> busy_vec[0]=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and source encoding for the register-file writeback path.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; grant bit 0 = ALU, bit 1 = MEM.
// last_grant | meaning
// SRC_ALU    | ALU won the last transfer, MEM wins the next contention
// SRC_MEM    | MEM won the last transfer (reset), ALU wins the next contention
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    src_e last_grant;
    src_e last_grant_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_MEM;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        grant           = 2'b00;
        last_grant_next = last_grant;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == SRC_MEM) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (accept && (grant != 2'b00)) begin
            last_grant_next = grant[1] ? SRC_MEM : SRC_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port
// and tracks registers with writes in flight for decode hazard stalls.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [NUM_REGS-1:0]   busy_vec
);
    import cpu_pkg::*;

    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REGS-1:0]   busy_next;

    assign req = {mem_valid, alu_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // Ready is the grant itself, held low while reset is asserted.
    assign alu_ready = grant[0] & rst_n;
    assign mem_ready = grant[1] & rst_n;
    assign accept    = |(req & grant);
    assign win_addr  = grant[1] ? mem_addr : alu_addr;
    assign win_data  = grant[1] ? mem_data : alu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (accept) begin
            rf_we    <= (win_addr != ADDR_WIDTH'(ZERO_REG));
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Issue is applied after commit so a newer producer keeps the register busy.
    always_comb begin
        busy_next = busy_vec;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized producers against a
// behavioural model of the writeback arbiter and scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who won last (0 = ALU, 1 = MEM), the pending write, busy set.
    bit          m_last_mem;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_busy;

    // Returns {mem_wins, alu_wins} from the round-robin rule.
    function automatic logic [1:0] model_grant();
        if (alu_valid && mem_valid) return m_last_mem ? 2'b01 : 2'b10;
        if (alu_valid)              return 2'b01;
        if (mem_valid)              return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0]  g;
        logic [31:0] nb;
        if (!rst_n) begin
            m_last_mem = 1'b1;
            m_we       = 1'b0;
            m_waddr    = '0;
            m_wdata    = '0;
            m_busy     = '0;
        end else begin
            g  = model_grant();
            nb = m_busy;
            if (m_we) nb[m_waddr] = 1'b0;
            if (issue_valid && issue_addr != 5'd0) nb[issue_addr] = 1'b1;
            m_busy = nb;
            if (g[0]) begin
                m_we = (alu_addr != 5'd0); m_waddr = alu_addr; m_wdata = alu_data; m_last_mem = 1'b0;
            end else if (g[1]) begin
                m_we = (mem_addr != 5'd0); m_waddr = mem_addr; m_wdata = mem_data; m_last_mem = 1'b1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        if (chk_en && rst_n) begin
            g = model_grant();
            check("alu_ready", 32'(alu_ready), 32'(g[0]));
            check("mem_ready", 32'(mem_ready), 32'(g[1]));
            check("rf_we",     32'(rf_we),     32'(m_we));
            check("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
            check("rf_wdata",  rf_wdata,       m_wdata);
            check("busy_vec",  busy_vec,       m_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit a_xfer, m_xfer;
        do_reset();
        chk_en = 1'b1;

        // Single ALU source
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("single_rf_we",    32'(rf_we),    32'd1);
        check("single_rf_waddr", 32'(rf_waddr), 32'd3);
        check("single_rf_wdata", rf_wdata,      32'hDEAD_BEEF);
        tick();

        // Contention after reset, sustained over six cycles
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("contend_alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
            check("contend_mem_ready", 32'(mem_ready), 32'((i % 2) == 1));
            if (i == 1) begin
                check("contend_wr1_addr", 32'(rf_waddr), 32'd4);
                check("contend_wr1_data", rf_wdata,      32'h11);
            end
            if (i == 2) begin
                check("contend_wr2_addr", 32'(rf_waddr), 32'd5);
                check("contend_wr2_data", rf_wdata,      32'h22);
            end
            tick();
            if ((i % 2) == 0) alu_data = 32'h11 + 32'(i) + 32'd2;
            else              mem_data = 32'h22 + 32'(i) + 32'd1;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Scoreboard set, then same-register set/clear collision
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check("sb_busy7_set", 32'(busy_vec[7]), 32'd1);
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0; issue_valid = 1'b1; issue_addr = 5'd7;
        @(negedge clk);
        check("sb_commit_we", 32'(rf_we), 32'd1);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check("sb_busy7_kept", 32'(busy_vec[7]), 32'd1);

        // Register zero
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("r0_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0; issue_valid = 1'b1; issue_addr = 5'd0;
        @(negedge clk);
        check("r0_rf_we", 32'(rf_we), 32'd0);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check("r0_busy0", 32'(busy_vec[0]), 32'd0);

        // Asynchronous reset with a pending write and busy registers 1 and 2
        do_reset();
        issue_valid = 1'b1; issue_addr = 5'd1;
        tick();
        issue_addr = 5'd2;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        tick();
        check("ar_busy_before", busy_vec, 32'h0000_0006);
        check("ar_we_before",   32'(rf_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_rf_we",     32'(rf_we),     32'd0);
        check("ar_busy_vec",  busy_vec,       32'd0);
        check("ar_alu_ready", 32'(alu_ready), 32'd0);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Randomized producers that hold their request until it transfers
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a_xfer = alu_valid && alu_ready;
            m_xfer = mem_valid && mem_ready;
            if (c == 1500) begin
                #1 rst_n = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
                rst_n = 1'b1;
                continue;
            end
            if (!alu_valid || a_xfer) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid || m_xfer) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_addr  = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = 5'($urandom_range(0, 31));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
